// File: rtl/io_ctrl_axil_slave.sv
// AXI4-Lite responder for the IO controller S00_AXI port.
// Four 32-bit read/write registers; reg0 drives gpio_out and reg1 drives gpio_oe.
// The write address and write data channels are accepted independently, with
// one outstanding write and one outstanding read at a time.
module io_ctrl_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   gpio_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   gpio_oe
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  // Register file
  logic [DW-1:0] regs [4];

  // Write channel state
  logic          aw_held;
  logic          w_held;
  logic [1:0]    aw_sel_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic          awready_q;
  logic          wready_q;
  logic          bvalid_q;

  // Read channel state
  logic          arready_q;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;

  // Write channel next-state terms
  logic          aw_hs;
  logic          w_hs;
  logic          aw_have;
  logic          w_have;
  logic          commit;
  logic          aw_held_nxt;
  logic          w_held_nxt;
  logic          bvalid_nxt;
  logic [1:0]    wr_sel;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;

  // Read channel next-state terms
  logic          ar_hs;
  logic          rvalid_nxt;
  logic [1:0]    rd_sel;

  // Protection bits and the byte-offset address bits carry no meaning here.
  logic          unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Byte-wise merge of new write data into an existing register value.
  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_val,
                                               input logic [DW-1:0] new_val,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_val;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // Write channel: handshakes, commit decision and next flag values.
  // A beat may be either already latched or arriving on this edge; the commit
  // takes whichever source is current so same-cycle AW+W needs no extra cycle.
  always_comb begin
    aw_hs       = S_AXI_AWVALID && awready_q;
    w_hs        = S_AXI_WVALID && wready_q;
    aw_have     = aw_held || aw_hs;
    w_have      = w_held || w_hs;
    commit      = aw_have && w_have;
    wr_sel      = aw_held ? aw_sel_q : S_AXI_AWADDR[3:2];
    wr_data     = w_held ? wdata_q : S_AXI_WDATA;
    wr_strb     = w_held ? wstrb_q : S_AXI_WSTRB;
    aw_held_nxt = commit ? 1'b0 : aw_have;
    w_held_nxt  = commit ? 1'b0 : w_have;
    bvalid_nxt  = bvalid_q;
    if (commit) begin
      bvalid_nxt = 1'b1;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_nxt = 1'b0;
    end
  end

  // Read channel: handshake and next RVALID value.
  always_comb begin
    ar_hs      = S_AXI_ARVALID && arready_q;
    rd_sel     = S_AXI_ARADDR[3:2];
    rvalid_nxt = rvalid_q;
    if (ar_hs) begin
      rvalid_nxt = 1'b1;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_nxt = 1'b0;
    end
  end

  // Write channel registers. Readies are registered from the next-state flags,
  // so they are low during reset and rise on the first edge after release, and
  // stay low while a response is waiting to be taken.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_sel_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      aw_held   <= aw_held_nxt;
      w_held    <= w_held_nxt;
      bvalid_q  <= bvalid_nxt;
      awready_q <= !aw_held_nxt && !bvalid_nxt;
      wready_q  <= !w_held_nxt && !bvalid_nxt;
      if (aw_hs) aw_sel_q <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Register file update on commit; a zero strobe commits without change.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[wr_sel] <= apply_strb(regs[wr_sel], wr_data, wr_strb);
    end
  end

  // Read channel registers. RDATA samples the register file before any
  // same-edge commit lands, so a colliding read returns the old value.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid_q  <= rvalid_nxt;
      arready_q <= !rvalid_nxt;
      if (ar_hs) rdata_q <= regs[rd_sel];
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign gpio_out      = regs[0];
  assign gpio_oe       = regs[1];

endmodule
